unidade_busca: RTL

//  Fetch/program-counter stage of the single-cycle MIPS core. Holds the PC and drives
//  the instruction memory address bus (word-aligned, 256-word memory indexed by addr[9:2]).

---
 rtl/unidade_busca.sv | 103 ++++++++++
 1 files changed

// File: rtl/unidade_busca.sv
// Fetch / program-counter stage of the single-cycle MIPS core: holds the PC, selects the
// next PC (sequential, branch, J/JAL, JR) and freezes in HALT or FAULT until reset.
module unidade_busca #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 256,
  parameter int          COUNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               branch_taken,
  input  logic [15:0]        imm,
  input  logic               jump,
  input  logic [25:0]        jtarget,
  input  logic               jump_reg,
  input  logic [31:0]        reg_target,
  input  logic               halt_req,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               halted,
  output logic               fault,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT,
    ST_FAULT
  } state_t;

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

  state_t               r_state;
  state_t               w_state_next;
  logic [31:0]          r_pc;
  logic [31:0]          w_pc_next;
  logic [COUNT_W-1:0]   r_count;
  logic [COUNT_W-1:0]   w_count_next;
  logic [31:0]          w_pc_plus4;
  logic [31:0]          w_npc;
  logic                 w_bad_target;

  assign w_pc_plus4 = r_pc + 32'd4;

  // Target selection: JR over J/JAL over branch over sequential; all arithmetic wraps at 32 bits.
  always_comb begin
    if (jump_reg)
      w_npc = reg_target;
    else if (jump)
      w_npc = {w_pc_plus4[31:28], jtarget, 2'b00};
    else if (branch_taken)
      w_npc = w_pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    else
      w_npc = w_pc_plus4;
  end

  // Wrapping past the last word is caught here too, since pc_plus4 then equals ADDR_LIMIT.
  assign w_bad_target = (w_npc[1:0] != 2'b00) || (w_npc >= ADDR_LIMIT);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_count_next = r_count;
    case (r_state)
      ST_RUN: begin
        if (en) begin
          if (halt_req) begin
            w_state_next = ST_HALT;
          end else if (w_bad_target) begin
            w_state_next = ST_FAULT;
          end else begin
            w_pc_next = w_npc;
            if (r_count != {COUNT_W{1'b1}})
              w_count_next = r_count + 1'b1;
          end
        end
      end
      ST_HALT, ST_FAULT: ;
      default: w_state_next = ST_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    if (reset) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_count <= w_count_next;
    end
  end

  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign halted      = (r_state == ST_HALT);
  assign fault       = (r_state == ST_FAULT);
  assign instr_count = r_count;

endmodule
